fifo_wr_arbiter: RTL and testbench

//  Round-robin, burst-based arbiter sharing the single write port of async_fifo among NREQ requesters.

---
 rtl/fifo_arb_pkg.sv | 33 +++
 rtl/rr_pick.sv | 46 ++++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helpers for the async_fifo write-port
// arbiter (fifo_wr_arbiter) and its round-robin picker (rr_pick).
//   state_t   - arbiter FSM states
//   id_w      - width of a requester index ($clog2(NREQ))
//   burst_w   - width of a counter that must hold 0..MAX_BURST
//   flush_w   - width of the flush down-counter (holds FLUSH_CYC-1)
//   wrap_idx  - single-step modulo wrap used by the rotating picker
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int flush_w(input int flush_cyc);
        return (flush_cyc > 1) ? $clog2(flush_cyc) : 1;
    endfunction

    // Callers guarantee i < 2*n, so one subtraction is enough.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     in   NREQ   request vector
//   last    in   ID_W   last grantee; search starts at last+1
//   gnt     out  NREQ   one-hot winner (all zero when no request)
//   gnt_idx out  ID_W   index of the winner (0 when no request)
// The request vector is rotated so that last+1 lands at bit 0, the lowest
// set bit is taken, and the position is rotated back to an absolute index.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic [NREQ-1:0] rot;
    int              base;
    int              pick;
    int              win;

    always_comb begin
        rot     = '0;
        gnt     = '0;
        gnt_idx = '0;
        base    = wrap_idx(int'(last) + 1, NREQ);
        pick    = 0;
        win     = 0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[wrap_idx(base + k, NREQ)];
        end
        // Scan downwards so the lowest set rotated bit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) pick = k;
        end
        win = wrap_idx(base + pick, NREQ);
        if (|rot) begin
            gnt[win] = 1'b1;
            gnt_idx  = ID_W'(win);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-based arbiter sharing the single write
// port of async_fifo among NREQ requesters; also sequences write-pointer
// flushes and latches over_flow as a sticky error. Write-clock domain only.
//   wclk, wrst       clock; synchronous active-high reset
//   req_valid/data   per-requester word and valid (lane i = [i*DSIZE +: DSIZE])
//   req_ready        per-requester accept, at most one bit high
//   fifo_full/near_full/over_flow   status from async_fifo
//   flush_req        single-cycle request to clear the FIFO write pointer
//   fifo_wen/wdata/wptr_clr         to async_fifo
//   grant_id         current or last grantee
//   busy             FSM not idle
//   ovf_err          sticky overflow error
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    input  logic                    fifo_near_full,
    input  logic                    fifo_over_flow,
    input  logic                    flush_req,
    output logic                    fifo_wen,
    output logic [DSIZE-1:0]        fifo_wdata,
    output logic                    fifo_wptr_clr,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    ovf_err
);

    localparam int ID_W = id_w(NREQ);
    localparam int BW   = burst_w(MAX_BURST);
    localparam int FW   = flush_w(FLUSH_CYC);

    state_t          state, state_nxt;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_lim;
    logic [FW-1:0]   flush_cnt;
    logic [NREQ-1:0] pick_oh;
    logic [ID_W-1:0] pick_idx;
    logic            xfer;
    logic            flush_entry;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req     (req_valid),
        .last    (grant_id),
        .gnt     (pick_oh),
        .gnt_idx (pick_idx)
    );

    assign fifo_wptr_clr = (state == FLUSH);
    assign busy          = (state != IDLE);
    assign flush_entry   = (state != FLUSH) && (state_nxt == FLUSH);

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        xfer       = 1'b0;
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
        unique case (state)
            IDLE: begin
                if (flush_req)                  state_nxt = FLUSH;
                else if (|pick_oh && !fifo_full) state_nxt = GRANT;
            end
            GRANT: begin
                // Ready is gated by full in the same cycle, so this block
                // can never write into a full FIFO.
                req_ready[grant_id] = !fifo_full;
                xfer                = req_valid[grant_id] && !fifo_full;
                fifo_wen            = xfer;
                if (xfer) fifo_wdata = req_data[int'(grant_id)*DSIZE +: DSIZE];
                // A flush still lets this cycle's word through.
                if (flush_req)
                    state_nxt = FLUSH;
                else if ((xfer && burst_cnt == burst_lim - BW'(1)) ||
                         !req_valid[grant_id] || fifo_full)
                    state_nxt = IDLE;
            end
            FLUSH: begin
                if (flush_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= IDLE;
            grant_id  <= ID_W'(NREQ - 1);
            burst_cnt <= '0;
            burst_lim <= '0;
            flush_cnt <= '0;
            ovf_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            // Set wins over the flush-entry clear.
            if (fifo_over_flow)   ovf_err <= 1'b1;
            else if (flush_entry) ovf_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (state_nxt == GRANT) begin
                        grant_id  <= pick_idx;
                        burst_lim <= fifo_near_full ? BW'(1) : BW'(MAX_BURST);
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (state_nxt != GRANT) burst_cnt <= '0;
                    else if (xfer)          burst_cnt <= burst_cnt + BW'(1);
                end
                default: ;
            endcase

            // Loaded with FLUSH_CYC-1 so FLUSH lasts exactly FLUSH_CYC cycles;
            // flush_req seen while flushing does not reload it.
            if (flush_entry)
                flush_cnt <= FW'(FLUSH_CYC - 1);
            else if (state == FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a burst-level reference model predicts every
// output for each driven cycle and queues it; a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int FLUSH_CYC = 2;
    localparam int IDW       = $clog2(NREQ);

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full = 1'b0, fifo_near_full = 1'b0;
    logic                  fifo_over_flow = 1'b0, flush_req = 1'b0;
    logic                  fifo_wen, fifo_wptr_clr, busy, ovf_err;
    logic [DSIZE-1:0]      fifo_wdata;
    logic [IDW-1:0]        grant_id;

    fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST), .FLUSH_CYC(FLUSH_CYC)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_near_full(fifo_near_full),
        .fifo_over_flow(fifo_over_flow), .flush_req(flush_req), .fifo_wen(fifo_wen),
        .fifo_wdata(fifo_wdata), .fifo_wptr_clr(fifo_wptr_clr), .grant_id(grant_id),
        .busy(busy), .ovf_err(ovf_err)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [NREQ-1:0]  rdy;
        logic             wen;
        logic [DSIZE-1:0] wd;
        logic             clr;
        logic             busy;
        logic [IDW-1:0]   gid;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who holds the port (-1 = nobody), words left in the
    // burst, flush cycles left, last grantee, sticky error.
    int m_cur = -1, m_left = 0, m_flush = 0, m_last = NREQ - 1;
    bit m_ovf = 1'b0, m_xfer = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge wclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("req_ready",     32'(req_ready),     32'(e.rdy));
            chk("fifo_wen",      32'(fifo_wen),      32'(e.wen));
            chk("fifo_wdata",    32'(fifo_wdata),    32'(e.wd));
            chk("fifo_wptr_clr", 32'(fifo_wptr_clr), 32'(e.clr));
            chk("busy",          32'(busy),          32'(e.busy));
            chk("grant_id",      32'(grant_id),      32'(e.gid));
            chk("ovf_err",       32'(ovf_err),       32'(e.ovf));
        end
    end

    function automatic logic [NREQ*DSIZE-1:0] rnd_data();
        logic [NREQ*DSIZE-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) r[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        return r;
    endfunction

    // Drive one cycle of inputs, queue this cycle's expected outputs, then
    // advance the model across the coming clock edge.
    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*DSIZE-1:0] d,
                         input bit full, input bit nf, input bit ovf, input bit fl, input bit rst);
        exp_t e;
        bit   enter_flush;
        int   nxt;
        @(posedge wclk);
        #1;
        req_valid = v; req_data = d; fifo_full = full; fifo_near_full = nf;
        fifo_over_flow = ovf; flush_req = fl; wrst = rst;

        m_xfer = (m_cur >= 0) && v[m_cur] && !full;
        e.rdy  = '0;
        if (m_cur >= 0 && !full) e.rdy[m_cur] = 1'b1;
        e.wen  = m_xfer;
        e.wd   = m_xfer ? d[m_cur*DSIZE +: DSIZE] : '0;
        e.clr  = (m_flush > 0);
        e.busy = (m_flush > 0) || (m_cur >= 0);
        e.gid  = IDW'(m_last);
        e.ovf  = m_ovf;
        exp_q.push_back(e);

        enter_flush = 1'b0;
        nxt = 0;
        if (rst) begin
            m_cur = -1; m_left = 0; m_flush = 0; m_last = NREQ - 1; m_ovf = 1'b0;
        end else begin
            if (m_flush > 0) begin
                m_flush--;
            end else if (m_cur >= 0) begin
                if (m_xfer) m_left--;
                if (fl) enter_flush = 1'b1;
                else if (m_left == 0 || !v[m_cur] || full) m_cur = -1;
            end else if (fl) begin
                enter_flush = 1'b1;
            end else if (v != '0 && !full) begin
                for (int k = 1; k <= NREQ; k++) begin
                    nxt = (m_last + k) % NREQ;
                    if (v[nxt]) break;
                end
                m_cur = nxt; m_last = nxt; m_left = nf ? 1 : MAX_BURST;
            end
            if (enter_flush) begin
                m_cur = -1; m_flush = FLUSH_CYC;
            end
            if (ovf) m_ovf = 1'b1;
            else if (enter_flush) m_ovf = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ*DSIZE-1:0] d;
        int n;
        repeat (2) @(posedge wclk);

        // All four requesters busy: rotating bursts of MAX_BURST.
        repeat (25) drive(4'hF, rnd_data(), 0, 0, 0, 0, 0);
        repeat (2)  drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // Lone requester 2 with ten words: bursts 4,4,2.
        n = 10;
        for (int c = 0; c < 60 && n > 0; c++) begin
            d = rnd_data();
            d[2*DSIZE +: DSIZE] = DSIZE'(8'hC0 + 10 - n);
            drive(4'b0100, d, 0, 0, 0, 0, 0);
            if (m_xfer) n--;
        end
        chk("req2_words_sent", 32'(n), 32'd0);
        repeat (2) drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // near_full at grant time: single-word burst.
        drive(4'hF, rnd_data(), 0, 1, 0, 0, 0);
        repeat (6) drive(4'hF, rnd_data(), 0, 0, 0, 0, 0);
        repeat (2) drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // full mid-burst: ready/wen drop at once, no re-grant while full.
        repeat (3) drive(4'hF, rnd_data(), 0, 0, 0, 0, 0);
        repeat (3) drive(4'hF, rnd_data(), 1, 0, 0, 0, 0);
        repeat (6) drive(4'hF, rnd_data(), 0, 0, 0, 0, 0);
        repeat (2) drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // over_flow pulse, then flush on 2nd word; repeated flush_req ignored.
        drive(4'h0, rnd_data(), 0, 0, 1, 0, 0);
        drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);
        drive(4'b0001, rnd_data(), 0, 0, 0, 0, 0);
        drive(4'b0001, rnd_data(), 0, 0, 0, 0, 0);
        drive(4'b0001, rnd_data(), 0, 0, 0, 1, 0);
        drive(4'b0001, rnd_data(), 0, 0, 0, 0, 0);
        drive(4'b0001, rnd_data(), 0, 0, 0, 1, 0);
        repeat (3) drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // Reset in GRANT.
        repeat (3) drive(4'hF, rnd_data(), 0, 0, 0, 0, 0);
        drive(4'hF, rnd_data(), 0, 0, 0, 0, 1);
        repeat (2) drive(4'h0, rnd_data(), 0, 0, 0, 0, 0);

        // Random traffic.
        repeat (400)
            drive(NREQ'($urandom), rnd_data(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 99) == 0);

        @(negedge wclk);
        @(posedge wclk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
